// File: rtl/pmem_line_responder.sv
// Backing-store responder for the L2 / write-buffer line interface: one line read or
// write at a time, fixed access latency, single-cycle pmem_resp completion pulse.
module pmem_line_responder #(
  parameter int LINE_BITS  = 128,
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [15:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 busy,
  output logic                 protocol_err
);

  // state  | meaning
  // S_IDLE | waiting for pmem_read / pmem_write
  // S_BUSY | request latched, latency counter running
  // S_RESP | pmem_resp cycle; write commits on the closing edge
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         DEPTH    = 1 << INDEX_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [LINE_BITS-1:0]  mem [DEPTH];

  logic                  req;
  logic                  rd_op;
  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] rd_idx;
  logic                  unused_addr;

  assign req         = pmem_read | pmem_write;
  assign req_idx     = pmem_address[4 +: INDEX_BITS];
  // Line offset and alias bits above the index carry no information for the store.
  assign unused_addr = ^pmem_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_idx  = idx_q;
    rd_op   = ~op_wr_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_wr_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_LOAD;
          if (pmem_read && pmem_write) err_d = 1'b1;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // With LATENCY==1 the resp state is entered straight from idle, so the
    // read must use the live request rather than the latched one.
    if (state_q == S_IDLE) begin
      rd_idx = req_idx;
      rd_op  = pmem_read & ~pmem_write;
    end
    if (state_d == S_RESP && state_q != S_RESP && rd_op) rdata_d = mem[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store is not reset; an abandoned write never reaches S_RESP so never commits.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && op_wr_q) mem[idx_q] <= wdata_q;
  end

  assign pmem_rdata   = rdata_q;
  assign pmem_resp    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: three builds (LATENCY 4, 1, 15) checked every cycle
// against a transaction-level model, plus literal readback and latency expectations.
module tb_pmem_line_responder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         rd_i    [3];
  logic         wr_i    [3];
  logic [15:0]  addr_i  [3];
  logic [127:0] wd_i    [3];
  logic [127:0] rdata_o [3];
  logic         resp_o  [3];
  logic         busy_o  [3];
  logic         err_o   [3];

  pmem_line_responder #(.LINE_BITS(128), .INDEX_BITS(6), .LATENCY(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd_i[0]), .pmem_write(wr_i[0]),
    .pmem_address(addr_i[0]), .pmem_wdata(wd_i[0]), .pmem_rdata(rdata_o[0]),
    .pmem_resp(resp_o[0]), .busy(busy_o[0]), .protocol_err(err_o[0]));

  pmem_line_responder #(.LINE_BITS(128), .INDEX_BITS(6), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd_i[1]), .pmem_write(wr_i[1]),
    .pmem_address(addr_i[1]), .pmem_wdata(wd_i[1]), .pmem_rdata(rdata_o[1]),
    .pmem_resp(resp_o[1]), .busy(busy_o[1]), .protocol_err(err_o[1]));

  pmem_line_responder #(.LINE_BITS(128), .INDEX_BITS(6), .LATENCY(15)) dut2 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd_i[2]), .pmem_write(wr_i[2]),
    .pmem_address(addr_i[2]), .pmem_wdata(wd_i[2]), .pmem_rdata(rdata_o[2]),
    .pmem_resp(resp_o[2]), .busy(busy_o[2]), .protocol_err(err_o[2]));

  function automatic int lat_of(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Transaction-level model: accept edge number, op, index, data per build.
  int           cyc = 0;
  logic         m_act   [3];
  logic         m_wr    [3];
  logic         m_err   [3];
  logic         m_rk    [3];
  int           m_acc   [3];
  logic [5:0]   m_idx   [3];
  logic [127:0] m_wd    [3];
  logic [127:0] m_rdata [3];
  logic [127:0] mem_m   [3][64];
  bit           mem_k   [3][64];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        m_act[d] = 1'b0; m_wr[d] = 1'b0; m_err[d] = 1'b0;
        m_rk[d] = 1'b1; m_rdata[d] = '0; m_acc[d] = 0;
        m_idx[d] = '0; m_wd[d] = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int d = 0; d < 3; d++) begin
        if (m_act[d] && cyc == m_acc[d] + lat_of(d)) begin
          if (m_wr[d]) begin
            mem_m[d][m_idx[d]] = m_wd[d];
            mem_k[d][m_idx[d]] = 1'b1;
          end
          m_act[d] = 1'b0;
        end else if (!m_act[d] && (rd_i[d] || wr_i[d])) begin
          m_act[d] = 1'b1;
          m_acc[d] = cyc;
          m_wr[d]  = wr_i[d];
          m_idx[d] = addr_i[d][9:4];
          m_wd[d]  = wd_i[d];
          if (rd_i[d] && wr_i[d]) m_err[d] = 1'b1;
        end
        if (m_act[d] && !m_wr[d] && cyc == m_acc[d] + lat_of(d) - 1) begin
          m_rdata[d] = mem_m[d][m_idx[d]];
          m_rk[d]    = mem_k[d][m_idx[d]];
        end
      end
    end
  end

  // Literal expectations posted by the stimulus, drained by the compare process.
  string        lit_name [256];
  int           lit_d    [256];
  logic [127:0] lit_act  [256];
  logic [127:0] lit_exp  [256];
  int           lit_wp = 0;
  int           lit_rp = 0;

  task automatic post(string n, int d, logic [127:0] a, logic [127:0] e);
    lit_name[lit_wp % 256] = n;
    lit_d[lit_wp % 256]    = d;
    lit_act[lit_wp % 256]  = a;
    lit_exp[lit_wp % 256]  = e;
    lit_wp = lit_wp + 1;
  endtask

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string n, int d, logic [127:0] a, logic [127:0] e);
    vectors = vectors + 1;
    if (a !== e) begin
      miscompares = miscompares + 1;
      if (miscompares <= 40)
        $display("FAIL %s dut%0d at t=%0t: got %h expected %h", n, d, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check("resp", d, 128'(resp_o[d]),
            128'(m_act[d] && cyc == m_acc[d] + lat_of(d) - 1));
      check("busy", d, 128'(busy_o[d]), 128'(m_act[d]));
      check("protocol_err", d, 128'(err_o[d]), 128'(m_err[d]));
      if (m_rk[d]) check("rdata", d, rdata_o[d], m_rdata[d]);
    end
    while (lit_rp != lit_wp) begin
      check(lit_name[lit_rp % 256], lit_d[lit_rp % 256],
            lit_act[lit_rp % 256], lit_exp[lit_rp % 256]);
      lit_rp = lit_rp + 1;
    end
  end

  // Drive a request, optionally scramble addr/wdata or drop the request while busy,
  // and wait (bounded) for resp. The request is left asserted for back-to-back use.
  task automatic txn(int d, bit rd, bit wr, logic [15:0] a, logic [127:0] w,
                     bit scr, int drop_at);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(posedge clk); #2;
    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wd_i[d] = w;
    while (!got && n < 40) begin
      @(posedge clk);
      n = n + 1;
      #2;
      if (scr) begin
        addr_i[d] = 16'($urandom);
        wd_i[d]   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (drop_at == n) begin rd_i[d] = 1'b0; wr_i[d] = 1'b0; end
      @(negedge clk);
      if (resp_o[d]) got = 1'b1;
    end
    post("resp_seen", d, 128'(got), 128'(1));
    post("resp_latency", d, 128'(n), 128'(lat_of(d)));
  endtask

  task automatic idle(int d, int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #2;
      rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    end
  endtask

  task automatic read_expect(string n, int d, logic [15:0] a, logic [127:0] e);
    txn(d, 1'b1, 1'b0, a, '0, 1'b0, 0);
    post(n, d, rdata_o[d], e);
    idle(d, 1);
  endtask

  task automatic rand_run(int d, int cnt);
    int r;
    bit rd, wr;
    logic [15:0] a;
    logic [127:0] w;
    for (int i = 0; i < cnt; i++) begin
      r  = $urandom_range(0, 15);
      wr = (r < 7) || (r == 15);
      rd = (r >= 7);
      a  = 16'($urandom);
      a[9:4] = 6'($urandom_range(0, 7));
      w  = {$urandom, $urandom, $urandom, $urandom};
      txn(d, rd, wr, a, w, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      idle(d, $urandom_range(0, 2));
    end
    idle(d, 1);
  endtask

  localparam logic [127:0] L1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] LA = 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] LC = 128'hC0C0_C0C0_0101_0101_CAFE_F00D_DEAD_BEEF;
  localparam logic [127:0] LD = 128'hD00D_D00D_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] LE = 128'hEEEE_0000_EEEE_0000_7777_8888_9999_AAAA;
  localparam logic [127:0] LF = 128'hF1F2_F3F4_F5F6_F7F8_0102_0304_0506_0708;
  localparam logic [127:0] LG = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
  localparam logic [127:0] LH = 128'h4848_4848_0000_0400_1357_9BDF_2468_ACE0;

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = '0; wd_i[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    post("reset_rdata", 0, rdata_o[0], '0);
    post("reset_busy", 0, 128'(busy_o[0]), '0);
    #2 reset_n = 1'b1;

    // write then read one line
    txn(0, 1'b0, 1'b1, 16'h0040, L1, 1'b0, 0);
    idle(0, 1);
    read_expect("t1_rdata", 0, 16'h0040, L1);

    // back-to-back: read asserted in the first idle cycle after resp
    txn(0, 1'b0, 1'b1, 16'h0010, LA, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 0);
    post("b2b_rdata", 0, rdata_o[0], LA);
    idle(0, 1);
    @(negedge clk);
    post("resp_width", 0, 128'(resp_o[0]), '0);

    // read and write together: write wins, error is sticky
    txn(0, 1'b1, 1'b1, 16'h0020, LC, 1'b0, 0);
    idle(0, 1);
    post("err_set", 0, 128'(err_o[0]), 128'(1));
    read_expect("both_rdata", 0, 16'h0020, LC);
    txn(0, 1'b0, 1'b1, 16'h0050, LA, 1'b0, 0);
    idle(0, 1);
    post("err_sticky", 0, 128'(err_o[0]), 128'(1));

    // inputs scrambled while busy, and request dropped early
    txn(0, 1'b0, 1'b1, 16'h0060, LD, 1'b1, 0);
    idle(0, 1);
    read_expect("scramble_rdata", 0, 16'h0060, LD);
    txn(0, 1'b0, 1'b1, 16'h0070, LE, 1'b0, 1);
    idle(0, 1);
    read_expect("drop_rdata", 0, 16'h0070, LE);

    // reset two cycles into a write: abandoned, not committed
    txn(0, 1'b0, 1'b1, 16'h0030, LF, 1'b0, 0);
    idle(0, 1);
    @(posedge clk); #2;
    wr_i[0] = 1'b1; addr_i[0] = 16'h0030; wd_i[0] = LG;
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    wr_i[0] = 1'b0;
    @(negedge clk);
    post("rst_resp", 0, 128'(resp_o[0]), '0);
    post("rst_busy", 0, 128'(busy_o[0]), '0);
    post("rst_err", 0, 128'(err_o[0]), '0);
    post("rst_rdata", 0, rdata_o[0], '0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    read_expect("rst_prior", 0, 16'h0030, LF);

    rand_run(0, 150);

    // LATENCY=1 build: alias 0x0400 onto line 0
    txn(1, 1'b0, 1'b1, 16'h0400, LH, 1'b0, 0);
    idle(1, 1);
    read_expect("alias_rdata", 1, 16'h0000, LH);
    txn(1, 1'b0, 1'b1, 16'h0040, L1, 1'b0, 0);
    txn(1, 1'b1, 1'b0, 16'h0040, '0, 1'b0, 0);
    post("lat1_b2b_rdata", 1, rdata_o[1], L1);
    idle(1, 1);
    rand_run(1, 80);

    // LATENCY=15 build
    txn(2, 1'b0, 1'b1, 16'h0C40, LD, 1'b1, 0);
    idle(2, 1);
    read_expect("lat15_rdata", 2, 16'h0040, LD);
    rand_run(2, 30);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
